// File: rtl/alu_exec_if.sv
// Request/response bundle between the EX-stage issue logic and alu_exec_unit.
// The master drives operations and consumes results; the slave is the execution unit.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_ctl;
  logic             sign;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [WIDTH-1:0] acc_out;

  modport master (
    output in_valid,
    output alu_ctl,
    output sign,
    output in_a,
    output in_b,
    output acc_clr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_zero,
    input  acc_out
  );

  modport slave (
    input  in_valid,
    input  alu_ctl,
    input  sign,
    input  in_a,
    input  in_b,
    input  acc_clr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_zero,
    output acc_out
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus iterative shift-add MUL/MAC.
// Define ALU_EXEC_MAC_EN to build the accumulator; otherwise MAC executes as MUL.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  alu_exec_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [4:0] OpAnd  = 5'b00000;
  localparam logic [4:0] OpOr   = 5'b00001;
  localparam logic [4:0] OpAdd  = 5'b00010;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSlt  = 5'b00111;
  localparam logic [4:0] OpNor  = 5'b01100;
  localparam logic [4:0] OpXor  = 5'b01101;
  localparam logic [4:0] OpSll  = 5'b10000;
  localparam logic [4:0] OpSrl  = 5'b11000;
  localparam logic [4:0] OpSra  = 5'b11001;
  localparam logic [4:0] OpMul  = 5'b11010;
  localparam logic [4:0] OpMac  = 5'b11011;
  localparam logic [4:0] OpRelu = 5'b11100;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StOut
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_shift_q, a_shift_d;
  logic [WIDTH-1:0] b_shift_q, b_shift_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             is_mul_op;
  logic             last_iter;
  logic             slt_lt;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] prod_step;
  logic [WIDTH-1:0] mult_res;

  assign bus.in_ready   = (state_q == StIdle) | ((state_q == StOut) & bus.out_ready);
  assign bus.out_valid  = (state_q == StOut);
  assign bus.out_result = result_q;
  assign bus.out_zero   = (result_q == '0);

  assign accept    = bus.in_valid & bus.in_ready;
  assign is_mul_op = (bus.alu_ctl == OpMul) | (bus.alu_ctl == OpMac);
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign shamt     = bus.in_a[4:0];
  assign slt_lt    = bus.sign ? ($signed(bus.in_a) < $signed(bus.in_b)) : (bus.in_a < bus.in_b);

  // Partial product including this cycle's add; the final iteration registers it directly.
  assign prod_step = prod_q + (b_shift_q[0] ? a_shift_q : '0);

  // Single-cycle datapath; unlisted codes fall back to ADD.
  always_comb begin
    alu_res = bus.in_a + bus.in_b;
    case (bus.alu_ctl)
      OpAnd:  alu_res = bus.in_a & bus.in_b;
      OpOr:   alu_res = bus.in_a | bus.in_b;
      OpAdd:  alu_res = bus.in_a + bus.in_b;
      OpSub:  alu_res = bus.in_a - bus.in_b;
      OpSlt:  alu_res = {{(WIDTH - 1){1'b0}}, slt_lt};
      OpNor:  alu_res = ~(bus.in_a | bus.in_b);
      OpXor:  alu_res = bus.in_a ^ bus.in_b;
      OpSll:  alu_res = bus.in_b << shamt;
      OpSrl:  alu_res = bus.in_b >> shamt;
      OpSra:  alu_res = WIDTH'($signed(bus.in_b) >>> shamt);
      OpRelu: alu_res = bus.in_a[WIDTH-1] ? '0 : bus.in_a;
      default: alu_res = bus.in_a + bus.in_b;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_shift_d = a_shift_q;
    b_shift_d = b_shift_q;
    prod_d    = prod_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle, StOut: begin
        if ((state_q == StOut) && bus.out_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          if (is_mul_op) begin
            a_shift_d = bus.in_a;
            b_shift_d = bus.in_b;
            prod_d    = '0;
            cnt_d     = '0;
            state_d   = StMult;
          end else begin
            result_d = alu_res;
            state_d  = StOut;
          end
        end
      end
      StMult: begin
        prod_d    = prod_step;
        a_shift_d = a_shift_q << 1;
        b_shift_d = b_shift_q >> 1;
        cnt_d     = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = mult_res;
          state_d  = StOut;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_shift_q <= '0;
      b_shift_q <= '0;
      prod_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_shift_q <= a_shift_d;
      b_shift_q <= b_shift_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
    end
  end

`ifdef ALU_EXEC_MAC_EN
  logic             is_mac_q, is_mac_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_base;

  // A clear on the MAC final edge applies before the add, leaving only the product.
  assign acc_base = bus.acc_clr ? '0 : acc_q;

  always_comb begin
    acc_d    = acc_base;
    is_mac_d = is_mac_q;
    if (accept && is_mul_op) begin
      is_mac_d = (bus.alu_ctl == OpMac);
    end
    if ((state_q == StMult) && last_iter && is_mac_q) begin
      acc_d = acc_base + prod_step;
    end
  end

  assign mult_res    = is_mac_q ? acc_d : prod_step;
  assign bus.acc_out = acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      is_mac_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      is_mac_q <= is_mac_d;
    end
  end
`else
  logic unused_acc_clr;

  assign unused_acc_clr = bus.acc_clr;
  assign mult_res       = prod_step;
  assign bus.acc_out    = '0;
`endif

endmodule
